// File: rtl/bg_level_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bg_level_ctrl_pkg
// Shared game-side types for the background level sequencer and the
// background drawer.
//   bg_ctrl_state_t : sequencer states (IDLE, FADE_OUT, SWAP, FADE_IN)
//   level_t         : 2-bit background level index
//   FADE_MAX        : full-brightness fade value
// -----------------------------------------------------------------------------
package bg_level_ctrl_pkg;

    typedef logic [1:0] level_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_OUT = 2'd1,
        SWAP     = 2'd2,
        FADE_IN  = 2'd3
    } bg_ctrl_state_t;

    localparam logic [3:0] FADE_MAX = 4'd15;

endpackage

// File: rtl/bg_level_ctrl_frame_tick_gen.sv
// -----------------------------------------------------------------------------
// frame_tick_gen
// One-cycle frame tick on the rising edge of vertical blank.
// Ports:
//   clk   in  : pixel clock
//   rst   in  : asynchronous reset, active-high
//   vblnk in  : vertical blank from the VGA timing chain
//   tick  out : high for one cycle when vblnk rises
// -----------------------------------------------------------------------------
module frame_tick_gen (
    input  logic clk,
    input  logic rst,
    input  logic vblnk,
    output logic tick
);

    logic vblnk_prev;

    // The history bit resets high: coming out of reset inside blanking must
    // not look like a fresh rising edge.
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vblnk_prev <= 1'b1;
        end else begin
            vblnk_prev <= vblnk;
        end
    end

    assign tick = vblnk & ~vblnk_prev;

endmodule

// File: rtl/bg_level_ctrl.sv
// -----------------------------------------------------------------------------
// bg_level_ctrl
// Background level sequencer: on a level-up/down request it fades the picture
// out, swaps the level, and fades back in. Every level/fade update lands on
// the cycle after a frame tick, i.e. inside vertical blanking.
// Parameters:
//   FADE_STEP_FRAMES : frame ticks per fade step (1..255)
//   MAX_LEVEL        : highest level index (level is 2 bits wide)
// Ports:
//   clk           in  : pixel clock
//   rst           in  : asynchronous reset, active-high
//   vblnk         in  : vertical blank
//   req_up        in  : request next level
//   req_down      in  : request previous level
//   restart       in  : synchronous force to level 0, full brightness, idle
//   level         out : current background level
//   fade          out : brightness, 15 = full, 0 = black
//   busy          out : high whenever the sequencer is not idle
//   level_changed out : one-cycle pulse on the cycle level updates
// -----------------------------------------------------------------------------
module bg_level_ctrl
    import bg_level_ctrl_pkg::*;
#(
    parameter int FADE_STEP_FRAMES = 2,
    parameter int MAX_LEVEL        = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vblnk,
    input  logic       req_up,
    input  logic       req_down,
    input  logic       restart,
    output logic [1:0] level,
    output logic [3:0] fade,
    output logic       busy,
    output logic       level_changed
);

    localparam logic [7:0] STEP_LAST = 8'(FADE_STEP_FRAMES - 1);
    localparam level_t     LEVEL_TOP = level_t'(MAX_LEVEL);

    bg_ctrl_state_t state;
    level_t         target;
    logic [7:0]     frame_cnt;
    logic           tick;

    frame_tick_gen u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .vblnk (vblnk),
        .tick  (tick)
    );

    // busy is registered alongside each state change rather than decoded from
    // state, so every output comes straight from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            target        <= '0;
            frame_cnt     <= '0;
            level         <= '0;
            fade          <= FADE_MAX;
            busy          <= 1'b0;
            level_changed <= 1'b0;
        end else begin
            level_changed <= 1'b0;

            if (restart) begin
                state     <= IDLE;
                target    <= '0;
                frame_cnt <= '0;
                level     <= '0;
                fade      <= FADE_MAX;
                busy      <= 1'b0;
            end else begin
                case (state)
                    // A tick coinciding with an accepted request is not
                    // counted: the counter starts from zero in FADE_OUT.
                    IDLE: begin
                        if (req_up && !req_down && (level < LEVEL_TOP)) begin
                            target    <= level_t'(level + 2'd1);
                            frame_cnt <= '0;
                            state     <= FADE_OUT;
                            busy      <= 1'b1;
                        end else if (req_down && !req_up && (level != 2'd0)) begin
                            target    <= level_t'(level - 2'd1);
                            frame_cnt <= '0;
                            state     <= FADE_OUT;
                            busy      <= 1'b1;
                        end
                    end

                    FADE_OUT: begin
                        if (tick) begin
                            if (frame_cnt == STEP_LAST) begin
                                frame_cnt <= '0;
                                fade      <= fade - 4'd1;
                                // fade is about to reach 0; stopping here is
                                // what keeps it from wrapping.
                                if (fade == 4'd1) begin
                                    state <= SWAP;
                                end
                            end else begin
                                frame_cnt <= frame_cnt + 8'd1;
                            end
                        end
                    end

                    SWAP: begin
                        if (tick) begin
                            level         <= target;
                            level_changed <= 1'b1;
                            frame_cnt     <= '0;
                            state         <= FADE_IN;
                        end
                    end

                    FADE_IN: begin
                        if (tick) begin
                            if (frame_cnt == STEP_LAST) begin
                                frame_cnt <= '0;
                                fade      <= fade + 4'd1;
                                if (fade == FADE_MAX - 4'd1) begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                end
                            end else begin
                                frame_cnt <= frame_cnt + 8'd1;
                            end
                        end
                    end

                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bg_level_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bg_level_ctrl
// Directed bench for bg_level_ctrl with default parameters
// (FADE_STEP_FRAMES = 2, MAX_LEVEL = 3). A frame is 5 cycles: vblnk high for
// 2 cycles, low for 3, so each frame carries exactly one tick.
// -----------------------------------------------------------------------------
module tb_bg_level_ctrl;

    logic       clk;
    logic       rst;
    logic       vblnk;
    logic       req_up;
    logic       req_down;
    logic       restart;
    logic [1:0] level;
    logic [3:0] fade;
    logic       busy;
    logic       level_changed;

    int assertions;
    int failures;
    int lc_cnt;
    int busy_ticks;

    bg_level_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .vblnk         (vblnk),
        .req_up        (req_up),
        .req_down      (req_down),
        .restart       (restart),
        .level         (level),
        .fade          (fade),
        .busy          (busy),
        .level_changed (level_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts level_changed cycles; a single pulse adds exactly one.
    always @(negedge clk) begin
        if (level_changed === 1'b1) lc_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertions++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Each frame raises vblnk once; busy is read in the cycle the DUT will see
    // the tick, which is how ticks-while-busy are counted.
    task automatic run_frames(input int n);
        for (int i = 0; i < n; i++) begin
            vblnk = 1'b1;
            if (busy === 1'b1) busy_ticks++;
            step();
            step();
            vblnk = 1'b0;
            step();
            step();
            step();
        end
    endtask

    task automatic pulse_up();
        req_up = 1'b1;
        step();
        req_up = 1'b0;
    endtask

    task automatic pulse_down();
        req_down = 1'b1;
        step();
        req_down = 1'b0;
    endtask

    initial begin
        assertions = 0;
        failures   = 0;
        lc_cnt     = 0;
        busy_ticks = 0;
        rst        = 1'b1;
        vblnk      = 1'b0;
        req_up     = 1'b0;
        req_down   = 1'b0;
        restart    = 1'b0;

        // Reset state
        step();
        step();
        check("rst_level", level, 0);
        check("rst_fade", fade, 15);
        check("rst_busy", busy, 0);
        check("rst_lc", level_changed, 0);
        rst = 1'b0;
        step();

        // Idle frames
        run_frames(3);
        check("idle_level", level, 0);
        check("idle_fade", fade, 15);
        check("idle_busy", busy, 0);
        check("idle_lc_cnt", lc_cnt, 0);

        // req_down at level 0 is ignored
        pulse_down();
        check("down_at0_busy", busy, 0);
        step();
        check("down_at0_level", level, 0);
        check("down_at0_fade", fade, 15);

        // Full 0 -> 1 sequence
        busy_ticks = 0;
        check("pre_req_busy", busy, 0);
        pulse_up();
        check("req_busy_rise", busy, 1);
        check("req_fade_hold", fade, 15);
        run_frames(1);
        check("fo_tick1_fade", fade, 15);
        run_frames(1);
        check("fo_tick2_fade", fade, 14);
        run_frames(26);
        check("fo_tick28_fade", fade, 1);
        check("fo_tick28_level", level, 0);
        run_frames(2);
        check("fo_end_fade", fade, 0);
        check("fo_end_busy", busy, 1);
        check("fo_end_level", level, 0);
        check("fo_end_lc_cnt", lc_cnt, 0);
        run_frames(1);
        check("swap_level", level, 1);
        check("swap_lc_cnt", lc_cnt, 1);
        check("swap_fade", fade, 0);
        run_frames(2);
        check("fi_tick2_fade", fade, 1);
        run_frames(26);
        check("fi_tick28_fade", fade, 14);
        check("fi_tick28_busy", busy, 1);
        run_frames(2);
        check("fi_end_fade", fade, 15);
        check("fi_end_busy", busy, 0);
        check("busy_tick_count", busy_ticks, 61);
        check("seq1_lc_cnt", lc_cnt, 1);
        run_frames(2);
        check("post_fade", fade, 15);
        check("post_level", level, 1);

        // Both requests together at level 1 are ignored
        req_up   = 1'b1;
        req_down = 1'b1;
        step();
        req_up   = 1'b0;
        req_down = 1'b0;
        check("both_busy", busy, 0);
        run_frames(2);
        check("both_level", level, 1);
        check("both_fade", fade, 15);

        // 1 -> 2 with extra requests during FADE_OUT and FADE_IN dropped
        pulse_up();
        check("seq2_busy", busy, 1);
        run_frames(5);
        pulse_up();
        run_frames(35);
        check("seq2_mid_level", level, 2);
        pulse_up();
        run_frames(21);
        check("seq2_end_busy", busy, 0);
        check("seq2_end_fade", fade, 15);
        check("seq2_end_level", level, 2);
        check("seq2_lc_cnt", lc_cnt, 2);
        run_frames(2);
        check("seq2_no_requeue", busy, 0);

        // 2 -> 3, then req_up at level 3 is ignored
        pulse_up();
        run_frames(61);
        check("seq3_level", level, 3);
        check("seq3_busy", busy, 0);
        pulse_up();
        check("up_at3_busy", busy, 0);
        run_frames(2);
        check("up_at3_level", level, 3);
        check("up_at3_fade", fade, 15);

        // 3 -> 2 via req_down
        pulse_down();
        check("down_busy", busy, 1);
        run_frames(61);
        check("down_level", level, 2);
        check("down_busy_end", busy, 0);
        check("down_lc_cnt", lc_cnt, 4);

        // restart mid FADE_OUT at fade 7, level 2
        pulse_up();
        run_frames(16);
        check("pre_restart_fade", fade, 7);
        check("pre_restart_level", level, 2);
        check("pre_restart_busy", busy, 1);
        restart = 1'b1;
        step();
        restart = 1'b0;
        check("restart_level", level, 0);
        check("restart_fade", fade, 15);
        check("restart_busy", busy, 0);
        run_frames(2);
        check("restart_lc_cnt", lc_cnt, 4);
        check("restart_idle", busy, 0);

        // Async reset during SWAP, released while vblnk is high
        pulse_up();
        run_frames(30);
        check("pre_rst_fade", fade, 0);
        check("pre_rst_busy", busy, 1);
        vblnk = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_level", level, 0);
        check("async_rst_fade", fade, 15);
        check("async_rst_busy", busy, 0);
        step();
        rst = 1'b0;
        check("rel_tick0", dut.u_tick_gen.tick, 0);
        step();
        check("rel_tick1", dut.u_tick_gen.tick, 0);
        step();
        check("rel_tick2", dut.u_tick_gen.tick, 0);
        vblnk = 1'b0;
        step();
        vblnk = 1'b1;
        #1;
        check("rel_tick_rise", dut.u_tick_gen.tick, 1);
        step();
        vblnk = 1'b0;
        step();
        check("rel_level", level, 0);
        check("rel_lc_cnt", lc_cnt, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

    // Hard stop in case the sequence above stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
